score_keeper: RTL and testbench



---
 rtl/score_pkg.sv | 25 ++
 rtl/score_keeper_bin2bcd_seq.sv | 56 +++++
 rtl/score_keeper.sv | 169 ++++++++++++++++
 tb/tb_score_keeper.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared state codes, ASCII constants and digit helpers for the score keeper.
package score_pkg;

  localparam int unsigned SCORE_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_GAME  = 2'b10,
    ST_SCORE = 2'b11
  } game_state_e;

  localparam logic [6:0] ASCII_ZERO = 7'h30;
  localparam logic [6:0] ASCII_ONE  = 7'h31;
  localparam logic [6:0] ASCII_TWO  = 7'h32;

  function automatic logic [6:0] to_ascii(input logic [3:0] digit);
    return {3'b011, digit};
  endfunction

  function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
    return ({3'b000, tens} * 7'd10) + {3'b000, units};
  endfunction

endpackage

// File: rtl/score_keeper_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: repeated subtract-by-10, one step per clock.
module bin2bcd_seq
  import score_pkg::*;
#(
  parameter int unsigned MAX_SCORE = 99
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic                 i_start,
  input  logic [SCORE_W-1:0]   i_value,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [3:0]           o_tens,
  output logic [3:0]           o_units
);

  logic [SCORE_W-1:0] r_rem;
  logic [3:0]         r_tens;
  logic               r_busy;
  logic               r_done;
  logic [SCORE_W-1:0] w_clamped;

  assign w_clamped = (i_value > SCORE_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : i_value;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_rem  <= '0;
      r_tens <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        if (r_rem >= SCORE_W'(10)) begin
          r_rem  <= r_rem - SCORE_W'(10);
          r_tens <= r_tens + 4'd1;
        end else begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (i_start) begin
        r_rem  <= w_clamped;
        r_tens <= '0;
        r_busy <= 1'b1;
      end
    end
  end

  // Remainder is below 10 once done, so its low nibble is the units digit.
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_tens  = r_tens;
  assign o_units = r_rem[3:0];

endmodule

// File: rtl/score_keeper.sv
// Tracks local and opponent scores and renders them as ASCII digits plus a winner code.
// Optional SCORE_LIMIT_EN macro enables the game_over threshold at WIN_SCORE.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned MAX_SCORE = 99
`ifdef SCORE_LIMIT_EN
  ,
  parameter int unsigned WIN_SCORE = 10
`endif
) (
  input  logic               i_pclk,
  input  logic               i_rst,
  input  logic [1:0]         i_state,
  input  logic               i_duck_clicked,
  input  logic [SCORE_W-1:0] i_op_score_bin,
  input  logic               i_op_score_valid,
  output logic [SCORE_W-1:0] o_my_score_bin,
  output logic [6:0]         o_my_score_ascii_1,
  output logic [6:0]         o_my_score_ascii_0,
  output logic [6:0]         o_op_score_ascii_1,
  output logic [6:0]         o_op_score_ascii_0,
  output logic [6:0]         o_number_of_player,
  output logic               o_conv_busy,
  output logic               o_game_over
);

  logic [1:0]         r_prev_state;
  logic               r_duck_q;
  logic [SCORE_W-1:0] r_my_bin;
  logic [3:0]         r_my_tens;
  logic [3:0]         r_my_units;
  logic [SCORE_W-1:0] r_op_bin;
  logic [SCORE_W-1:0] r_pend_bin;
  logic               r_pend_valid;

  logic               w_in_game;
  logic               w_entry;
  logic               w_rise;
  logic               w_hit;
  logic               w_locked;
  logic               w_accept;
  logic               w_start;
  logic [SCORE_W-1:0] w_start_value;
  logic               w_conv_busy;
  logic               w_conv_done;
  logic [3:0]         w_op_tens;
  logic [3:0]         w_op_units;

  assign w_in_game = (i_state == ST_GAME);
  assign w_entry   = w_in_game && (r_prev_state != ST_GAME);
  assign w_rise    = i_duck_clicked & ~r_duck_q;
  assign w_hit     = w_rise && w_in_game && !w_entry && !w_locked;

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      r_prev_state <= ST_IDLE;
      r_duck_q     <= 1'b0;
    end else begin
      r_prev_state <= i_state;
      r_duck_q     <= i_duck_clicked;
    end
  end

  // Local score: BCD and binary counters advance together and hold at MAX_SCORE.
  always_ff @(posedge i_pclk) begin
    if (i_rst || w_entry) begin
      r_my_bin   <= '0;
      r_my_tens  <= '0;
      r_my_units <= '0;
    end else if (w_hit && (r_my_bin < SCORE_W'(MAX_SCORE))) begin
      r_my_bin <= r_my_bin + SCORE_W'(1);
      if (r_my_units == 4'd9) begin
        r_my_units <= '0;
        r_my_tens  <= r_my_tens + 4'd1;
      end else begin
        r_my_units <= r_my_units + 4'd1;
      end
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      o_my_score_bin     <= '0;
      o_my_score_ascii_1 <= ASCII_ZERO;
      o_my_score_ascii_0 <= ASCII_ZERO;
    end else begin
      o_my_score_bin     <= r_my_bin;
      o_my_score_ascii_1 <= to_ascii(r_my_tens);
      o_my_score_ascii_0 <= to_ascii(r_my_units);
    end
  end

  // Opponent strobes: start directly when idle, otherwise park the newest in pending.
  assign w_accept      = i_op_score_valid && !w_entry && !w_locked;
  assign w_start       = !w_conv_busy && (w_accept || r_pend_valid) && !w_entry && !w_locked;
  assign w_start_value = w_accept ? i_op_score_bin : r_pend_bin;

  always_ff @(posedge i_pclk) begin
    if (i_rst || w_entry) begin
      r_pend_bin   <= '0;
      r_pend_valid <= 1'b0;
    end else if (w_accept && w_conv_busy) begin
      r_pend_bin   <= i_op_score_bin;
      r_pend_valid <= 1'b1;
    end else if (w_start) begin
      r_pend_valid <= 1'b0;
    end
  end

  bin2bcd_seq #(
    .MAX_SCORE (MAX_SCORE)
  ) u_bin2bcd_seq (
    .i_clk   (i_pclk),
    .i_rst   (i_rst),
    .i_clear (w_entry),
    .i_start (w_start),
    .i_value (w_start_value),
    .o_busy  (w_conv_busy),
    .o_done  (w_conv_done),
    .o_tens  (w_op_tens),
    .o_units (w_op_units)
  );

  assign o_conv_busy = w_conv_busy;

  always_ff @(posedge i_pclk) begin
    if (i_rst || w_entry) begin
      r_op_bin           <= '0;
      o_op_score_ascii_1 <= ASCII_ZERO;
      o_op_score_ascii_0 <= ASCII_ZERO;
    end else if (w_conv_done) begin
      r_op_bin           <= bcd_to_bin(w_op_tens, w_op_units);
      o_op_score_ascii_1 <= to_ascii(w_op_tens);
      o_op_score_ascii_0 <= to_ascii(w_op_units);
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      o_number_of_player <= ASCII_ZERO;
    end else if (r_my_bin > r_op_bin) begin
      o_number_of_player <= ASCII_ONE;
    end else if (r_op_bin > r_my_bin) begin
      o_number_of_player <= ASCII_TWO;
    end else begin
      o_number_of_player <= ASCII_ZERO;
    end
  end

`ifdef SCORE_LIMIT_EN
  logic r_game_over;

  always_ff @(posedge i_pclk) begin
    if (i_rst || w_entry) begin
      r_game_over <= 1'b0;
    end else if ((r_my_bin >= SCORE_W'(WIN_SCORE)) || (r_op_bin >= SCORE_W'(WIN_SCORE))) begin
      r_game_over <= 1'b1;
    end
  end

  assign w_locked    = r_game_over;
  assign o_game_over = r_game_over;
`else
  assign w_locked    = 1'b0;
  assign o_game_over = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper; opponent results are checked through an expectation queue.
module tb_score_keeper;

  logic       i_pclk = 1'b0;
  logic       i_rst;
  logic [1:0] i_state;
  logic       i_duck_clicked;
  logic [6:0] i_op_score_bin;
  logic       i_op_score_valid;
  logic [6:0] o_my_score_bin;
  logic [6:0] o_my_score_ascii_1;
  logic [6:0] o_my_score_ascii_0;
  logic [6:0] o_op_score_ascii_1;
  logic [6:0] o_op_score_ascii_0;
  logic [6:0] o_number_of_player;
  logic       o_conv_busy;
  logic       o_game_over;

  typedef struct packed {
    logic [6:0] a1;
    logic [6:0] a0;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  score_keeper u_dut (
    .i_pclk             (i_pclk),
    .i_rst              (i_rst),
    .i_state            (i_state),
    .i_duck_clicked     (i_duck_clicked),
    .i_op_score_bin     (i_op_score_bin),
    .i_op_score_valid   (i_op_score_valid),
    .o_my_score_bin     (o_my_score_bin),
    .o_my_score_ascii_1 (o_my_score_ascii_1),
    .o_my_score_ascii_0 (o_my_score_ascii_0),
    .o_op_score_ascii_1 (o_op_score_ascii_1),
    .o_op_score_ascii_0 (o_op_score_ascii_0),
    .o_number_of_player (o_number_of_player),
    .o_conv_busy        (o_conv_busy),
    .o_game_over        (o_game_over)
  );

  always #5 i_pclk = ~i_pclk;

  task automatic cyc();
    @(negedge i_pclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_op(input int v);
    exp_t e;
    int   c;
    c    = (v > 99) ? 99 : v;
    e.a1 = 7'(8'h30 + c / 10);
    e.a0 = 7'(8'h30 + c % 10);
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=output expected=empty_queue", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_tens"}, o_op_score_ascii_1, e.a1);
      chk({tag, "_units"}, o_op_score_ascii_0, e.a0);
    end
  endtask

  // Waits for a conversion to finish, then compares the output registered one edge later.
  task automatic wait_op(input string tag);
    logic prev;
    logic found;
    prev  = o_conv_busy;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc();
      if (prev && !o_conv_busy) found = 1'b1;
      prev = o_conv_busy;
    end
    if (!found) begin
      total++;
      bad++;
      $error("FAIL %s observed=timeout expected=conv_done", tag);
    end else begin
      cyc();
      pop_check(tag);
    end
  endtask

  task automatic hit();
    i_duck_clicked = 1'b1;
    cyc();
    i_duck_clicked = 1'b0;
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst            = 1'b1;
    i_state          = 2'b00;
    i_duck_clicked   = 1'b0;
    i_op_score_bin   = '0;
    i_op_score_valid = 1'b0;
    repeat (3) cyc();
    chk("rst_my1", o_my_score_ascii_1, 7'h30);
    chk("rst_my0", o_my_score_ascii_0, 7'h30);
    chk("rst_op1", o_op_score_ascii_1, 7'h30);
    chk("rst_op0", o_op_score_ascii_0, 7'h30);
    chk("rst_nop", o_number_of_player, 7'h30);
    chk("rst_bin", o_my_score_bin, 0);
    chk("rst_busy", o_conv_busy, 0);
    chk("rst_go", o_game_over, 0);
    i_rst = 1'b0;
    cyc();

    i_state = 2'b10;
    cyc();
`ifdef SCORE_LIMIT_EN
    repeat (9) hit();
    i_duck_clicked = 1'b1;
    cyc();
    chk("lim_go_early", o_game_over, 0);
    i_duck_clicked = 1'b0;
    cyc();
    chk("lim_go_set", o_game_over, 1);
    chk("lim_bin10", o_my_score_bin, 10);
    hit();
    cyc();
    chk("lim_bin_hold", o_my_score_bin, 10);
    chk("lim_go_hold", o_game_over, 1);
    i_op_score_valid = 1'b1;
    i_op_score_bin   = 7'd5;
    cyc();
    i_op_score_valid = 1'b0;
    chk("lim_strobe_ign", o_conv_busy, 0);
    i_state = 2'b01;
    cyc();
    i_state = 2'b10;
    cyc();
    chk("lim_go_clear", o_game_over, 0);
    cyc();
    chk("lim_bin_clear", o_my_score_bin, 0);
    hit();
    cyc();
    chk("lim_bin_after", o_my_score_bin, 1);
`else
    for (int n = 0; n < 12; n++) begin
      i_duck_clicked = 1'b1;
      repeat (5) cyc();
      i_duck_clicked = 1'b0;
      repeat (5) cyc();
    end
    chk("t2_bin", o_my_score_bin, 12);
    chk("t2_my1", o_my_score_ascii_1, 7'h31);
    chk("t2_my0", o_my_score_ascii_0, 7'h32);
    chk("t2_nop", o_number_of_player, 7'h31);

    i_op_score_valid = 1'b1;
    i_op_score_bin   = 7'd37;
    push_op(37);
    cyc();
    i_op_score_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("t4_busy", o_conv_busy, (k < 4) ? 1 : 0);
      if (k == 4) chk("t4_early", o_op_score_ascii_1, 7'h30);
      if (k == 5) pop_check("t4_op");
      if (k < 5) cyc();
    end
    cyc();
    chk("t4_nop", o_number_of_player, 7'h32);

    repeat (105) hit();
    cyc();
    chk("t3_bin", o_my_score_bin, 99);
    chk("t3_my1", o_my_score_ascii_1, 7'h39);
    chk("t3_my0", o_my_score_ascii_0, 7'h39);
    chk("t3_nop", o_number_of_player, 7'h31);
    i_state = 2'b01;
    cyc();
    repeat (5) hit();
    cyc();
    chk("t3_wait_bin", o_my_score_bin, 99);
    chk("t3_go", o_game_over, 0);

    i_op_score_valid = 1'b1;
    i_op_score_bin   = 7'd50;
    push_op(50);
    cyc();
    i_op_score_valid = 1'b0;
    cyc();
    i_op_score_valid = 1'b1;
    i_op_score_bin   = 7'd8;
    cyc();
    i_op_score_bin   = 7'd20;
    push_op(20);
    cyc();
    i_op_score_valid = 1'b0;
    wait_op("t5_first");
    wait_op("t5_second");
    cyc();
    chk("t5_nop", o_number_of_player, 7'h31);
    chk("t5_q_empty", exp_q.size(), 0);

    // Re-entry with a coincident rise and strobe: both must be dropped.
    i_state          = 2'b10;
    i_duck_clicked   = 1'b1;
    i_op_score_valid = 1'b1;
    i_op_score_bin   = 7'd44;
    cyc();
    i_op_score_valid = 1'b0;
    chk("t5_entry_busy", o_conv_busy, 0);
    cyc();
    chk("t5_entry_bin", o_my_score_bin, 0);
    chk("t5_entry_my1", o_my_score_ascii_1, 7'h30);
    chk("t5_entry_my0", o_my_score_ascii_0, 7'h30);
    chk("t5_entry_op1", o_op_score_ascii_1, 7'h30);
    chk("t5_entry_op0", o_op_score_ascii_0, 7'h30);
    chk("t5_entry_nop", o_number_of_player, 7'h30);
    i_duck_clicked = 1'b0;
    cyc();
    hit();
    cyc();
    chk("t5_after_bin", o_my_score_bin, 1);
    chk("t5_after_my0", o_my_score_ascii_0, 7'h31);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
